// File: rtl/rhd_pkg.sv
// Shared types, CRC constants and the bit-serial CRC-16/CCITT word update
// for the RHD frame packer.
package rhd_pkg;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    FILL     = 1'b1
  } state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam int unsigned CRC_DW_MAX = 64;

  // Folds the low dw bits of data into crc, most significant bit first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc,
                                             input logic [CRC_DW_MAX-1:0] data,
                                             input int unsigned dw);
    logic [15:0] c;
    logic        fb;
    logic [5:0]  bi;
    c  = crc;
    fb = 1'b0;
    bi = '0;
    for (int unsigned i = 0; i < CRC_DW_MAX; i++) begin
      if (i < dw) begin
        bi = 6'(dw - 1 - i);
        fb = c[15] ^ data[bi];
        c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/rhd_crc16_acc.sv
// Per-word CRC-16/CCITT accumulator; clr restarts from the init value on the
// same word it is asserted with, crc_next_c includes the current word.
module rhd_crc16_acc
  import rhd_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [15:0]   crc_next_c
);

  logic [15:0] crc_q;
  logic [15:0] base_c;

  always_comb begin
    base_c     = clr ? CRC16_INIT : crc_q;
    crc_next_c = crc16_word(base_c, CRC_DW_MAX'(data), DW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC16_INIT;
    end else if (en) begin
      crc_q <= crc_next_c;
    end
  end

endmodule

// File: rtl/rhd_frame_packer.sv
// Assembles SOF-aligned RHD words into N_CH*N_SAMP-word frames and hands them
// to the transmitter over valid/ready. FRAME_CRC_EN adds a per-frame m_crc.
module rhd_frame_packer
  import rhd_pkg::*;
#(
  parameter int unsigned N_CH   = 32,
  parameter int unsigned N_SAMP = 2,
  parameter int unsigned DW     = 16,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  input  logic                     s_sof,
  output logic [N_CH*N_SAMP*DW-1:0] m_frame,
  output logic [ID_W-1:0]          m_frame_id,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [31:0]              frame_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         resync_cnt
`ifdef FRAME_CRC_EN
  ,
  output logic [15:0]              m_crc
`endif
);

  localparam int unsigned W  = N_CH * N_SAMP;
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  state_e          state_q, state_next;
  logic [IW-1:0]   idx_q, idx_next;
  logic [IW-1:0]   wr_idx;
  logic            wr_en;
  logic            start;
  logic            resync;
  logic            complete;
  logic            slot_free;
  logic [ID_W-1:0] next_id;
  logic [DW-1:0]   fill_q [W];
  logic [W*DW-1:0] frame_c;

  // State and word index register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SOF;
      idx_q   <= '0;
    end else begin
      state_q <= state_next;
      idx_q   <= idx_next;
    end
  end

  // Next-state, write steering and frame-event decode
  always_comb begin
    state_next = state_q;
    idx_next   = idx_q;
    wr_en      = 1'b0;
    wr_idx     = idx_q;
    start      = 1'b0;
    resync     = 1'b0;
    complete   = 1'b0;
    if (s_valid) begin
      unique case (state_q)
        WAIT_SOF: begin
          if (s_sof) begin
            wr_en      = 1'b1;
            wr_idx     = '0;
            start      = 1'b1;
            idx_next   = IW'(1);
            state_next = FILL;
          end
        end
        FILL: begin
          wr_en = 1'b1;
          if (s_sof) begin
            resync   = (idx_q != '0);
            wr_idx   = '0;
            start    = 1'b1;
            idx_next = IW'(1);
          end else begin
            wr_idx   = idx_q;
            idx_next = idx_q + IW'(1);
          end
        end
        default: state_next = WAIT_SOF;
      endcase
    end
    if (wr_en && (wr_idx == IW'(W - 1))) begin
      complete = 1'b1;
      idx_next = '0;
    end
  end

  assign slot_free = !m_valid || m_ready;

  // Completed frame: the buffered words plus the last word arriving this cycle
  always_comb begin
    frame_c = '0;
    for (int unsigned k = 0; k < W; k++) begin
      frame_c[k*DW +: DW] = (k == W - 1) ? s_data : fill_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < W; k++) begin
        fill_q[k] <= '0;
      end
    end else if (wr_en) begin
      fill_q[wr_idx] <= s_data;
    end
  end

  // Output slot, frame id and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      m_frame    <= '0;
      m_frame_id <= '0;
      m_valid    <= 1'b0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      resync_cnt <= '0;
      next_id    <= '0;
    end else begin
      if (complete && slot_free) begin
        m_frame    <= frame_c;
        m_frame_id <= next_id;
        m_valid    <= 1'b1;
        frame_cnt  <= frame_cnt + 32'd1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (complete && !slot_free && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (complete) begin
        next_id <= next_id + ID_W'(1);
      end
      if (resync && (resync_cnt != '1)) begin
        resync_cnt <= resync_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FRAME_CRC_EN
  logic [15:0] crc_next;

  rhd_crc16_acc #(
    .DW (DW)
  ) u_crc (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .en         (wr_en),
    .data       (s_data),
    .crc_next_c (crc_next)
  );

  // CRC travels with the frame it covers
  always_ff @(posedge clk) begin
    if (rst) begin
      m_crc <= '0;
    end else if (complete && slot_free) begin
      m_crc <= crc_next;
    end
  end
`else
  logic unused_start;
  assign unused_start = start;
`endif

endmodule

// File: tb/tb_rhd_frame_packer.sv
// Directed bench for rhd_frame_packer (4 ch x 2 samples, 16-bit words,
// 2-bit counters so saturation is reachable); checks m_crc when FRAME_CRC_EN.
module tb_rhd_frame_packer;

  localparam int unsigned N_CH = 4, N_SAMP = 2, DW = 16, ID_W = 8, CNT_W = 2;
  localparam int unsigned W = N_CH * N_SAMP;

  logic                 clk;
  logic                 rst;
  logic [DW-1:0]        s_data;
  logic                 s_valid;
  logic                 s_sof;
  logic [W*DW-1:0]      m_frame;
  logic [ID_W-1:0]      m_frame_id;
  logic                 m_valid;
  logic                 m_ready;
  logic [31:0]          frame_cnt;
  logic [CNT_W-1:0]     drop_cnt;
  logic [CNT_W-1:0]     resync_cnt;
`ifdef FRAME_CRC_EN
  logic [15:0]          m_crc;
`endif

  int total = 0;
  int bad   = 0;

  rhd_frame_packer #(
    .N_CH(N_CH), .N_SAMP(N_SAMP), .DW(DW), .ID_W(ID_W), .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_sof      (s_sof),
    .m_frame    (m_frame),
    .m_frame_id (m_frame_id),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt),
    .resync_cnt (resync_cnt)
`ifdef FRAME_CRC_EN
    ,
    .m_crc      (m_crc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One word presented for exactly one edge; returns 1 time unit after that edge.
  task automatic word(input logic sof, input logic [DW-1:0] d);
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] base);
    for (int i = 0; i < W; i++) word(i == 0, base + DW'(i));
  endtask

  function automatic logic [127:0] mk_frame(input logic [DW-1:0] base);
    logic [127:0] f;
    f = '0;
    for (int k = 0; k < W; k++) f[k*DW +: DW] = base + DW'(k);
    return f;
  endfunction

`ifdef FRAME_CRC_EN
  function automatic logic [15:0] crc_ref_zero_frame();
    logic [15:0] c;
    c = 16'hFFFF;
    for (int n = 0; n < W * DW; n++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_valid", 128'(m_valid), 128'(0));
    chk("rst_frame", 128'(m_frame), 128'(0));
    chk("rst_id", 128'(m_frame_id), 128'(0));
    chk("rst_fcnt", 128'(frame_cnt), 128'(0));
    chk("rst_drop", 128'(drop_cnt), 128'(0));
    chk("rst_resync", 128'(resync_cnt), 128'(0));

    // Words before any SOF are ignored
    for (int i = 0; i < 5; i++) word(1'b0, 16'hAAA0 + 16'(i));
    chk("presync_valid", 128'(m_valid), 128'(0));

    // Basic frame with one-cycle latency
    for (int i = 0; i < W - 1; i++) word(i == 0, 16'(i));
    chk("basic_not_yet", 128'(m_valid), 128'(0));
    word(1'b0, 16'h0007);
    chk("basic_valid", 128'(m_valid), 128'(1));
    chk("basic_frame", 128'(m_frame), mk_frame(16'h0000));
    chk("basic_id", 128'(m_frame_id), 128'(0));
    chk("basic_fcnt", 128'(frame_cnt), 128'(1));
    chk("basic_resync", 128'(resync_cnt), 128'(0));
    idle();
    chk("accept_drop_valid", 128'(m_valid), 128'(0));

    send_frame(16'h0010);
    chk("second_frame", 128'(m_frame), mk_frame(16'h0010));
    chk("second_id", 128'(m_frame_id), 128'(1));
    chk("second_fcnt", 128'(frame_cnt), 128'(2));
    idle();

    // Resync: partial frame abandoned by a new SOF
    for (int i = 0; i < 4; i++) word(i == 0, 16'h0100 + 16'(i));
    send_frame(16'h0200);
    chk("resync_cnt", 128'(resync_cnt), 128'(1));
    chk("resync_frame", 128'(m_frame), mk_frame(16'h0200));
    chk("resync_id", 128'(m_frame_id), 128'(2));
    chk("resync_fcnt", 128'(frame_cnt), 128'(3));
    idle();

    // Backpressure: first frame held, second dropped
    m_ready = 1'b0;
    send_frame(16'h0300);
    chk("bp_a_id", 128'(m_frame_id), 128'(3));
    send_frame(16'h0400);
    chk("bp_drop", 128'(drop_cnt), 128'(1));
    chk("bp_hold_frame", 128'(m_frame), mk_frame(16'h0300));
    chk("bp_hold_id", 128'(m_frame_id), 128'(3));
    chk("bp_fcnt", 128'(frame_cnt), 128'(4));

    // Back-to-back: accept and completion on the same edge
    for (int i = 0; i < W - 1; i++) word(i == 0, 16'h0500 + 16'(i));
    m_ready = 1'b1;
    word(1'b0, 16'h0507);
    chk("b2b_valid", 128'(m_valid), 128'(1));
    chk("b2b_frame", 128'(m_frame), mk_frame(16'h0500));
    chk("b2b_id", 128'(m_frame_id), 128'(5));
    chk("b2b_drop", 128'(drop_cnt), 128'(1));
    chk("b2b_fcnt", 128'(frame_cnt), 128'(5));
    idle();
    chk("b2b_release", 128'(m_valid), 128'(0));

    // Reset mid-frame with a frame pending
    m_ready = 1'b0;
    send_frame(16'h0600);
    for (int i = 0; i < 3; i++) word(i == 0, 16'h0700 + 16'(i));
    rst = 1'b1;
    word(1'b0, 16'h0703);
    rst = 1'b0;
    chk("mrst_valid", 128'(m_valid), 128'(0));
    chk("mrst_frame", 128'(m_frame), 128'(0));
    chk("mrst_id", 128'(m_frame_id), 128'(0));
    chk("mrst_fcnt", 128'(frame_cnt), 128'(0));
    chk("mrst_drop", 128'(drop_cnt), 128'(0));
    m_ready = 1'b1;
    for (int i = 0; i < W - 1; i++) word(1'b0, 16'h0800 + 16'(i));
    chk("mrst_waitsof", 128'(m_valid), 128'(0));
    send_frame(16'h0900);
    chk("mrst_frame2", 128'(m_frame), mk_frame(16'h0900));
    chk("mrst_id2", 128'(m_frame_id), 128'(0));
    chk("mrst_fcnt2", 128'(frame_cnt), 128'(1));

    // Counter saturation at all-ones
    m_ready = 1'b0;
    for (int f = 0; f < 4; f++) send_frame(16'h1000 + 16'(f * 16));
    chk("sat_drop", 128'(drop_cnt), 128'(3));
    chk("sat_hold", 128'(m_frame), mk_frame(16'h0900));
    for (int i = 0; i < 5; i++) begin
      word(1'b1, 16'h2000);
      word(1'b0, 16'h2001);
    end
    chk("sat_resync", 128'(resync_cnt), 128'(3));
    m_ready = 1'b1;
    idle();
    chk("sat_release", 128'(m_valid), 128'(0));

    // All-zero frame; id continues past the dropped frames
    for (int i = 0; i < W; i++) word(i == 0, 16'h0000);
    chk("zero_frame", 128'(m_frame), 128'(0));
    chk("zero_id", 128'(m_frame_id), 128'(5));
    chk("zero_fcnt", 128'(frame_cnt), 128'(2));
`ifdef FRAME_CRC_EN
    chk("zero_crc", 128'(m_crc), 128'(crc_ref_zero_frame()));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
